// File: rtl/pipe_stall_ctrl.sv
// Central stall scheduler for the 5-stage pipeline: arbitrates ID/EX/MEM stall requests,
// drives the per-stage stall bus and times out multi-cycle EX ops. Optional macro: PIPE_STALL_PERF_EN.
module pipe_stall_ctrl #(
    parameter int MC_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        mc_start,
    input  logic        mc_done,
    input  logic        mem_wait,
    output logic [5:0]  stall,
    output logic        inst_hold,
    output logic        mc_abort,
    output logic        busy,
    output logic [31:0] stall_cycles
);

    localparam int CW = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MC_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MC_WAIT  = 2'b01,
        ST_MEM_WAIT = 2'b10
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [CW-1:0] tmo_cnt_r;
    logic [CW-1:0] tmo_cnt_next_s;
    logic          timeout_s;
    logic          ex_src_s;
    logic [5:0]    stall_s;
    logic          inst_hold_r;

    // Request sources, timeout detection and the priority-encoded stall pattern
    always_comb begin
        timeout_s = 1'b0;
        ex_src_s  = 1'b0;
        stall_s   = STALL_NONE;
        if (!rst) begin
            timeout_s = (state_r == ST_MC_WAIT) && (tmo_cnt_r == CNT_LAST) && !mc_done;
            // A firing timeout withdraws the EX request in the same cycle
            ex_src_s  = ((state_r == ST_MC_WAIT) && !mc_done && !timeout_s) ||
                        ((state_r == ST_RUN) && mc_start && !mc_done);
            if (mem_wait) begin
                stall_s = STALL_MEM;
            end else if (ex_src_s) begin
                stall_s = STALL_EX;
            end else if (stallreq_id) begin
                stall_s = STALL_ID;
            end else begin
                stall_s = STALL_NONE;
            end
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Next-state and timeout-counter update
    always_comb begin
        state_next_s   = state_r;
        tmo_cnt_next_s = {CW{1'b0}};
        case (state_r)
            ST_RUN: begin
                if (mem_wait) begin
                    state_next_s = ST_MEM_WAIT;
                end else if (mc_start && !mc_done) begin
                    state_next_s = ST_MC_WAIT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_MC_WAIT: begin
                if (mc_done || timeout_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s   = ST_MC_WAIT;
                    tmo_cnt_next_s = tmo_cnt_r + CNT_ONE;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_wait) begin
                    state_next_s = ST_MEM_WAIT;
                end else if (mc_start && !mc_done) begin
                    state_next_s = ST_MC_WAIT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
    end

    // State, timeout counter and held-instruction strobe registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_RUN;
            tmo_cnt_r   <= {CW{1'b0}};
            inst_hold_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            tmo_cnt_r   <= tmo_cnt_next_s;
            inst_hold_r <= stall_s[1];
        end
    end

`ifdef PIPE_STALL_PERF_EN
    logic [31:0] stall_cycles_r;

    // Count every cycle in which the PC is held; wraps naturally at 32 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_r <= 32'h0000_0000;
        end else if (stall_s[0]) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign stall_cycles = stall_cycles_r;
`else
    assign stall_cycles = 32'h0000_0000;
`endif

    assign stall     = stall_s;
    assign inst_hold = inst_hold_r;
    assign mc_abort  = timeout_s;
    assign busy      = (state_r != ST_RUN);

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed test-plan sequences followed by
// randomized stimulus, all checked against a behavioural model of the stall rules.
module tb_pipe_stall_ctrl;

    localparam int T = 8;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        mc_start;
    logic        mc_done;
    logic        mem_wait;
    logic [5:0]  stall;
    logic        inst_hold;
    logic        mc_abort;
    logic        busy;
    logic [31:0] stall_cycles;

    int n_cmp;
    int n_err;

    // Reference model: mode 0 = running, 1 = waiting on multi-cycle op, 2 = waiting on memory
    int          m_mode;
    int          m_age;
    logic        m_hold;
    logic [31:0] m_perf;

    pipe_stall_ctrl #(.MC_TIMEOUT(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .mc_start     (mc_start),
        .mc_done      (mc_done),
        .mem_wait     (mem_wait),
        .stall        (stall),
        .inst_hold    (inst_hold),
        .mc_abort     (mc_abort),
        .busy         (busy),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, check mid-cycle, then advance the model across the clock edge
    task automatic step(input logic r, input logic id, input logic ms, input logic md, input logic mw);
        int          deep;
        logic        tmo;
        logic        ex;
        logic [5:0]  e_stall;
        int          nxt;
        rst = r; stallreq_id = id; mc_start = ms; mc_done = md; mem_wait = mw;
        #4;
        tmo = (m_mode == 1) && (m_age == T - 1) && !md && !r;
        ex  = ((m_mode == 1) && !md && !tmo) || ((m_mode == 0) && ms && !md);
        deep = -1;
        if (id) deep = 2;
        if (ex) deep = 3;
        if (mw) deep = 4;
        e_stall = (r || deep < 0) ? 6'd0 : 6'((1 << (deep + 1)) - 1);
        chk("stall", 32'(stall), 32'(e_stall));
        chk("mc_abort", 32'(mc_abort), 32'(tmo));
        chk("busy", 32'(busy), 32'(m_mode != 0));
        chk("inst_hold", 32'(inst_hold), 32'(m_hold));
        chk("stall_cycles", stall_cycles, m_perf);
        @(posedge clk);
        if (r) begin
            m_mode = 0; m_age = 0; m_hold = 1'b0; m_perf = 32'd0;
        end else begin
            m_hold = e_stall[1];
`ifdef PIPE_STALL_PERF_EN
            if (e_stall[0]) m_perf = m_perf + 32'd1;
`endif
            if (m_mode == 1) nxt = (md || tmo) ? 0 : 1;
            else if (mw) nxt = 2;
            else if (ms && !md) nxt = 1;
            else nxt = 0;
            m_age = (m_mode == 1 && nxt == 1) ? m_age + 1 : 0;
            m_mode = nxt;
        end
        #1;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        m_mode = 0; m_age = 0; m_hold = 1'b0; m_perf = 32'd0;
        rst = 1'b1; stallreq_id = 1'b0; mc_start = 1'b0; mc_done = 1'b0; mem_wait = 1'b0;
        @(posedge clk); #1;
        // Reset with noisy inputs: outputs must stay quiet
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Load-use single pulse
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Multi-cycle op of 5 cycles
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Single-cycle op and a stray mc_done in RUN
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        // Timeout: start plus 8 wait cycles, then release
        for (int i = 0; i < T + 1; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Priority inside MC_WAIT
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        // Memory wait then direct hand-off into MC_WAIT
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        // Reset on the third MC_WAIT cycle
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Perf scenario: 3 load-use stalls plus a 4-cycle MC op
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 4) == 0));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
